// File: rtl/sd_spi_init_seq.sv
// sd_spi_init_seq
// SD-card SPI-mode initialisation sequencer feeding an SPI master.
// Issues power-up clocks, CMD0, CMD8, CMD55/ACMD41 polling and CMD58.
// Each transaction is a handshake: the frame and lengths are loaded, then
// spi_start is raised. Success and failure are reported to the storage
// controller, together with the card capacity class.
//
// Ports
//   clk, rst_n             system clock, async active-low reset
//   init_start             level request, accepted in IDLE/DONE/ERROR only
//   init_done/init_error   held status; err_code gives the failing stage
//                          (1 CMD0, 2 CMD8, 3 CMD55, 4 ACMD41, 5 CMD58,
//                          6 SPI timeout)
//   card_hc                OCR CCS bit (1 = SDHC/SDXC)
//   spi_start              transaction request to the SPI master
//   clk_ss                 0 = 400 kHz, 1 = 20 MHz (only in DONE)
//   cs_force_high          CS held high (power-up clocks only)
//   cmd_frame              48-bit command, MSB first
//   cmd_length             bytes to send
//   response_length        response bytes expected
//   receive/send_data_length  unused data phases, tied to 0
//   busy_spi               SPI master busy
//   valid_response         response strobe (resp_data valid)
//   valid_spi              transaction-complete strobe
//   resp_data              response bytes, R1 in [39:32]
//
// state      | meaning
// S_IDLE     | waiting for init_start
// S_PWRUP_*  | 0xFF bytes with CS forced high
// S_CMD0_*   | GO_IDLE_STATE, retried until R1 = 0x01
// S_CMD8_*   | SEND_IF_COND, selects v1/v2 card
// S_CMD55_*  | APP_CMD prefix
// S_ACMD41_* | SD_SEND_OP_COND poll
// S_GAP      | idle wait between ACMD41 rounds
// S_CMD58_*  | READ_OCR, captures CCS
// S_DONE     | init complete, fast clock
// S_ERROR    | init failed, err_code valid
// (*_I = load frame for one cycle, *_W = transaction in flight)

module sd_spi_init_seq #(
    parameter int CMD_WIDTH        = 48,
    parameter int POWERUP_BYTES    = 10,
    parameter int MAX_CMD0_TRIES   = 8,
    parameter int MAX_ACMD41_TRIES = 1000,
    parameter int RETRY_GAP        = 1000,
    parameter int SPI_TIMEOUT      = 2**22
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init_start,
    output logic                 init_done,
    output logic                 init_error,
    output logic [2:0]           err_code,
    output logic                 card_hc,
    output logic                 spi_start,
    output logic                 clk_ss,
    output logic                 cs_force_high,
    output logic [CMD_WIDTH-1:0] cmd_frame,
    output logic [5:0]           cmd_length,
    output logic [5:0]           response_length,
    output logic [9:0]           receive_data_length,
    output logic [9:0]           send_data_length,
    input  logic                 busy_spi,
    input  logic                 valid_response,
    input  logic                 valid_spi,
    input  logic [39:0]          resp_data
);

    localparam int WD_W   = $clog2(SPI_TIMEOUT + 1);
    localparam int CMD0_W = $clog2(MAX_CMD0_TRIES + 1);
    localparam int A41_W  = $clog2(MAX_ACMD41_TRIES + 1);
    localparam int GAP_W  = $clog2(RETRY_GAP + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_PWRUP_I,
        S_PWRUP_W,
        S_CMD0_I,
        S_CMD0_W,
        S_CMD8_I,
        S_CMD8_W,
        S_CMD55_I,
        S_CMD55_W,
        S_ACMD41_I,
        S_ACMD41_W,
        S_GAP,
        S_CMD58_I,
        S_CMD58_W,
        S_DONE,
        S_ERROR
    } state_t;

    state_t state;
    state_t state_next;

    logic [WD_W-1:0]   wd_cnt;
    logic [CMD0_W-1:0] cmd0_tries;
    logic [A41_W-1:0]  acmd41_rounds;
    logic [GAP_W-1:0]  gap_cnt;
    logic              v2;
    logic              got_resp;
    logic [39:0]       resp_reg;
    logic [39:0]       resp_now;
    logic [7:0]        r1;

    logic              restart;
    logic              cmd0_fail;
    logic              acmd41_fail;
    logic              v2_set;
    logic              v2_clr;
    logic              hc_load;
    logic              hc_val;
    logic              gap_load;
    logic [2:0]        err_next;
    logic              wd_expired;

    logic [CMD_WIDTH-1:0] cfg_frame;
    logic [5:0]           cfg_clen;
    logic [5:0]           cfg_rlen;
    logic                 cfg_cs;
    logic                 load_cfg;

    function automatic logic is_issue(input state_t s);
        return (s == S_PWRUP_I) || (s == S_CMD0_I) || (s == S_CMD8_I) ||
               (s == S_CMD55_I) || (s == S_ACMD41_I) || (s == S_CMD58_I);
    endfunction

    function automatic logic is_wait(input state_t s);
        return (s == S_PWRUP_W) || (s == S_CMD0_W) || (s == S_CMD8_W) ||
               (s == S_CMD55_W) || (s == S_ACMD41_W) || (s == S_CMD58_W);
    endfunction

    // crc argument is the whole last byte (CRC7 plus end bit)
    function automatic logic [CMD_WIDTH-1:0] make_frame(input logic [5:0]  idx,
                                                        input logic [31:0] arg,
                                                        input logic [7:0]  crc);
        return CMD_WIDTH'({2'b01, idx, arg, crc});
    endfunction

    // A response strobe in the same cycle as completion still counts;
    // with no response at all the card is treated as silent (all ones).
    assign resp_now = valid_response ? resp_data :
                      (got_resp ? resp_reg : '1);
    assign r1       = resp_now[39:32];

    logic unused_resp_bits;
    assign unused_resp_bits = ^{resp_now[31], resp_now[29:12]};

    assign wd_expired = is_wait(state) && (wd_cnt == WD_W'(SPI_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        restart     = 1'b0;
        cmd0_fail   = 1'b0;
        acmd41_fail = 1'b0;
        v2_set      = 1'b0;
        v2_clr      = 1'b0;
        hc_load     = 1'b0;
        hc_val      = 1'b0;
        gap_load    = 1'b0;
        err_next    = 3'd0;

        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (init_start) begin
                    state_next = S_PWRUP_I;
                    restart    = 1'b1;
                end
            end
            S_PWRUP_I:  state_next = S_PWRUP_W;
            S_CMD0_I:   state_next = S_CMD0_W;
            S_CMD8_I:   state_next = S_CMD8_W;
            S_CMD55_I:  state_next = S_CMD55_W;
            S_ACMD41_I: state_next = S_ACMD41_W;
            S_CMD58_I:  state_next = S_CMD58_W;
            S_PWRUP_W: begin
                if (valid_spi) state_next = S_CMD0_I;
            end
            S_CMD0_W: begin
                if (valid_spi) begin
                    if (r1 == 8'h01) begin
                        state_next = S_CMD8_I;
                    end else if (cmd0_tries == CMD0_W'(MAX_CMD0_TRIES - 1)) begin
                        state_next = S_ERROR;
                        err_next   = 3'd1;
                    end else begin
                        cmd0_fail  = 1'b1;
                        state_next = S_CMD0_I;
                    end
                end
            end
            S_CMD8_W: begin
                if (valid_spi) begin
                    if (r1 == 8'h01 && resp_now[11:0] == 12'h1AA) begin
                        v2_set     = 1'b1;
                        state_next = S_CMD55_I;
                    end else if (r1 == 8'h05) begin
                        v2_clr     = 1'b1;
                        state_next = S_CMD55_I;
                    end else begin
                        state_next = S_ERROR;
                        err_next   = 3'd2;
                    end
                end
            end
            S_CMD55_W: begin
                if (valid_spi) begin
                    if (r1 == 8'h00 || r1 == 8'h01) begin
                        state_next = S_ACMD41_I;
                    end else begin
                        state_next = S_ERROR;
                        err_next   = 3'd3;
                    end
                end
            end
            S_ACMD41_W: begin
                if (valid_spi) begin
                    if (r1 == 8'h00) begin
                        if (v2) begin
                            state_next = S_CMD58_I;
                        end else begin
                            hc_load    = 1'b1;
                            hc_val     = 1'b0;
                            state_next = S_DONE;
                        end
                    end else if (r1 == 8'h01 &&
                                 acmd41_rounds != A41_W'(MAX_ACMD41_TRIES - 1)) begin
                        acmd41_fail = 1'b1;
                        gap_load    = 1'b1;
                        state_next  = S_GAP;
                    end else begin
                        state_next = S_ERROR;
                        err_next   = 3'd4;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == '0) state_next = S_CMD55_I;
            end
            S_CMD58_W: begin
                if (valid_spi) begin
                    if (r1 == 8'h00) begin
                        hc_load    = 1'b1;
                        hc_val     = resp_now[30];
                        state_next = S_DONE;
                    end else begin
                        state_next = S_ERROR;
                        err_next   = 3'd5;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase

        // A completing transaction wins over the watchdog in the same cycle.
        if (wd_expired && !valid_spi) begin
            state_next  = S_ERROR;
            err_next    = 3'd6;
            restart     = 1'b0;
            cmd0_fail   = 1'b0;
            acmd41_fail = 1'b0;
            v2_set      = 1'b0;
            v2_clr      = 1'b0;
            hc_load     = 1'b0;
            gap_load    = 1'b0;
        end
    end

    // Transaction parameters are computed for the state being entered so
    // that the frame is already on the bus one cycle before spi_start.
    always_comb begin
        cfg_frame = '1;
        cfg_clen  = 6'd6;
        cfg_rlen  = 6'd1;
        cfg_cs    = 1'b0;
        case (state_next)
            S_PWRUP_I: begin
                cfg_frame = '1;
                cfg_clen  = 6'(POWERUP_BYTES);
                cfg_rlen  = 6'd0;
                cfg_cs    = 1'b1;
            end
            S_CMD0_I:   cfg_frame = make_frame(6'd0, 32'h0000_0000, 8'h95);
            S_CMD8_I: begin
                cfg_frame = make_frame(6'd8, 32'h0000_01AA, 8'h87);
                cfg_rlen  = 6'd5;
            end
            S_CMD55_I:  cfg_frame = make_frame(6'd55, 32'h0000_0000, 8'h01);
            S_ACMD41_I: cfg_frame = make_frame(6'd41, v2 ? 32'h4000_0000 : 32'h0000_0000, 8'h01);
            S_CMD58_I: begin
                cfg_frame = make_frame(6'd58, 32'h0000_0000, 8'h01);
                cfg_rlen  = 6'd5;
            end
            default: ;
        endcase
    end

    assign load_cfg = is_issue(state_next) && (state_next != state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_frame       <= '0;
            cmd_length      <= '0;
            response_length <= '0;
            cs_force_high   <= 1'b0;
            spi_start       <= 1'b0;
            wd_cnt          <= '0;
            got_resp        <= 1'b0;
            resp_reg        <= '0;
            cmd0_tries      <= '0;
            acmd41_rounds   <= '0;
            gap_cnt         <= '0;
            v2              <= 1'b0;
            card_hc         <= 1'b0;
            err_code        <= '0;
        end else begin
            if (load_cfg) begin
                cmd_frame       <= cfg_frame;
                cmd_length      <= cfg_clen;
                response_length <= cfg_rlen;
                cs_force_high   <= cfg_cs;
            end

            if (is_issue(state)) begin
                spi_start <= 1'b1;
            end else if (busy_spi || !is_wait(state_next)) begin
                spi_start <= 1'b0;
            end

            wd_cnt <= is_wait(state) ? wd_cnt + 1'b1 : '0;

            if (is_issue(state)) begin
                got_resp <= 1'b0;
            end else if (valid_response) begin
                got_resp <= 1'b1;
                resp_reg <= resp_data;
            end

            if (restart) begin
                cmd0_tries    <= '0;
                acmd41_rounds <= '0;
                v2            <= 1'b0;
                card_hc       <= 1'b0;
                err_code      <= '0;
            end else begin
                if (cmd0_fail)   cmd0_tries    <= cmd0_tries + 1'b1;
                if (acmd41_fail) acmd41_rounds <= acmd41_rounds + 1'b1;
                if (v2_set)      v2            <= 1'b1;
                if (v2_clr)      v2            <= 1'b0;
                if (hc_load)     card_hc       <= hc_val;
                if (err_next != 3'd0) err_code <= err_next;
            end

            if (gap_load) begin
                gap_cnt <= GAP_W'(RETRY_GAP - 1);
            end else if (state == S_GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

    assign init_done           = (state == S_DONE);
    assign init_error          = (state == S_ERROR);
    assign clk_ss              = (state == S_DONE);
    assign receive_data_length = '0;
    assign send_data_length    = '0;

endmodule

// File: tb/tb_sd_spi_init_seq.sv
module tb_sd_spi_init_seq;

    localparam int TB_GAP     = 20;
    localparam int TB_TIMEOUT = 300;

    localparam logic [47:0] F_PWR    = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] F_CMD0   = 48'h40_0000_0000_95;
    localparam logic [47:0] F_CMD8   = 48'h48_0000_01AA_87;
    localparam logic [47:0] F_CMD55  = 48'h77_0000_0000_01;
    localparam logic [47:0] F_A41_V2 = 48'h69_4000_0000_01;
    localparam logic [47:0] F_A41_V1 = 48'h69_0000_0000_01;
    localparam logic [47:0] F_CMD58  = 48'h7A_0000_0000_01;

    logic        clk;
    logic        rst_n;
    logic        init_start;
    logic        init_done;
    logic        init_error;
    logic [2:0]  err_code;
    logic        card_hc;
    logic        spi_start;
    logic        clk_ss;
    logic        cs_force_high;
    logic [47:0] cmd_frame;
    logic [5:0]  cmd_length;
    logic [5:0]  response_length;
    logic [9:0]  receive_data_length;
    logic [9:0]  send_data_length;
    logic        busy_spi;
    logic        valid_response;
    logic        valid_spi;
    logic [39:0] resp_data;

    sd_spi_init_seq #(
        .RETRY_GAP   (TB_GAP),
        .SPI_TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .init_start          (init_start),
        .init_done           (init_done),
        .init_error          (init_error),
        .err_code            (err_code),
        .card_hc             (card_hc),
        .spi_start           (spi_start),
        .clk_ss              (clk_ss),
        .cs_force_high       (cs_force_high),
        .cmd_frame           (cmd_frame),
        .cmd_length          (cmd_length),
        .response_length     (response_length),
        .receive_data_length (receive_data_length),
        .send_data_length    (send_data_length),
        .busy_spi            (busy_spi),
        .valid_response      (valid_response),
        .valid_spi           (valid_spi),
        .resp_data           (resp_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [47:0] frame;
        logic [5:0]  clen;
        logic [5:0]  rlen;
        logic        cs;
    } txn_t;

    typedef struct {
        int          cmd0_bad;
        logic [39:0] cmd8_resp;
        logic [7:0]  cmd55_r1;
        int          a41_busy;
        logic [7:0]  a41_final;
        logic [39:0] cmd58_resp;
        logic        exp_done;
        logic [2:0]  exp_code;
        logic        exp_hc;
        int          exp_n55;
    } vec_t;

    int   checks;
    int   failures;
    int   resp_mode;
    int   n0, n41, n55;
    vec_t cur;
    vec_t vecs[8];
    txn_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic txn_t mk(input logic [47:0] f, input logic [5:0] cl,
                                input logic [5:0] rl, input logic cs);
        txn_t t;
        t.frame = f;
        t.clen  = cl;
        t.rlen  = rl;
        t.cs    = cs;
        return t;
    endfunction

    // Expected command stream for one table entry.
    task automatic push_expected(input vec_t v);
        logic is_v2;
        exp_q.push_back(mk(F_PWR, 6'd10, 6'd0, 1'b1));
        for (int j = 0; j <= v.cmd0_bad; j++) exp_q.push_back(mk(F_CMD0, 6'd6, 6'd1, 1'b0));
        exp_q.push_back(mk(F_CMD8, 6'd6, 6'd5, 1'b0));
        if (v.exp_code == 3'd2) return;
        is_v2 = (v.cmd8_resp[39:32] == 8'h01);
        for (int k = 0; k <= v.a41_busy; k++) begin
            exp_q.push_back(mk(F_CMD55, 6'd6, 6'd1, 1'b0));
            if (v.exp_code == 3'd3) return;
            exp_q.push_back(mk(is_v2 ? F_A41_V2 : F_A41_V1, 6'd6, 6'd1, 1'b0));
        end
        if (is_v2 && v.exp_code != 3'd4) exp_q.push_back(mk(F_CMD58, 6'd6, 6'd5, 1'b0));
    endtask

    // Card / SPI-master model: pops the scoreboard on each request and
    // answers according to the current scenario.
    initial begin : responder
        txn_t        t;
        txn_t        e;
        logic [5:0]  idx;
        logic        give;
        logic [39:0] r;
        busy_spi       = 1'b0;
        valid_response = 1'b0;
        valid_spi      = 1'b0;
        resp_data      = '0;
        forever begin
            @(negedge clk);
            if (resp_mode == 0 && rst_n && spi_start) begin
                t = mk(cmd_frame, cmd_length, response_length, cs_force_high);
                check("sb_pending", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sb_frame", 64'(t.frame), 64'(e.frame));
                    check("sb_cmd_len", 64'(t.clen), 64'(e.clen));
                    check("sb_resp_len", 64'(t.rlen), 64'(e.rlen));
                    check("sb_cs_high", 64'(t.cs), 64'(e.cs));
                end
                idx  = t.frame[45:40];
                give = 1'b1;
                r    = '1;
                if (t.cs) begin
                    give = 1'b0;
                end else begin
                    case (idx)
                        6'd0: begin
                            give = (n0 >= cur.cmd0_bad);
                            r    = {8'h01, 32'hFFFF_FFFF};
                            n0++;
                        end
                        6'd8:  r = cur.cmd8_resp;
                        6'd55: begin
                            r = {cur.cmd55_r1, 32'hFFFF_FFFF};
                            n55++;
                        end
                        6'd41: begin
                            r = {(n41 < cur.a41_busy) ? 8'h01 : cur.a41_final, 32'hFFFF_FFFF};
                            n41++;
                        end
                        6'd58: r = cur.cmd58_resp;
                        default: give = 1'b0;
                    endcase
                end
                @(negedge clk);
                if (rst_n) check("start_held", 64'(spi_start), 64'd1);
                @(negedge clk);
                busy_spi = 1'b1;
                @(negedge clk);
                check("start_drop", 64'(spi_start), 64'd0);
                @(negedge clk);
                if (give) begin
                    valid_response = 1'b1;
                    resp_data      = r;
                    @(negedge clk);
                    valid_response = 1'b0;
                    resp_data      = '0;
                end else begin
                    @(negedge clk);
                end
                valid_spi = 1'b1;
                busy_spi  = 1'b0;
                @(negedge clk);
                valid_spi = 1'b0;
            end
        end
    end

    task automatic pulse_start(input string name);
        @(negedge clk);
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        check({name, "_restart_clear"},
              64'({init_done, init_error, err_code, card_hc, clk_ss}), 64'd0);
    endtask

    task automatic wait_end(input string name);
        int c;
        c = 0;
        while (!(init_done || init_error) && c < 5000) begin
            @(negedge clk);
            c++;
        end
        check({name, "_end_reached"}, 64'(init_done || init_error), 64'd1);
    endtask

    task automatic run_vec(input int i);
        string nm;
        nm = $sformatf("vec%0d", i);
        cur = vecs[i];
        n0 = 0; n41 = 0; n55 = 0;
        exp_q.delete();
        push_expected(cur);
        resp_mode = 0;
        pulse_start(nm);
        wait_end(nm);
        check({nm, "_done"}, 64'(init_done), 64'(cur.exp_done));
        check({nm, "_error"}, 64'(init_error), 64'(!cur.exp_done));
        check({nm, "_err_code"}, 64'(err_code), 64'(cur.exp_code));
        check({nm, "_card_hc"}, 64'(card_hc), 64'(cur.exp_hc));
        check({nm, "_clk_ss"}, 64'(clk_ss), 64'(cur.exp_done));
        check({nm, "_n_cmd55"}, 64'(n55), 64'(cur.exp_n55));
        check({nm, "_sb_drained"}, 64'(exp_q.size()), 64'd0);
        check({nm, "_spi_idle"}, 64'(spi_start), 64'd0);
    endtask

    initial begin
        #200_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin : main
        int n;
        int c;
        logic held;
        checks = 0; failures = 0;
        resp_mode = 1;
        n0 = 0; n41 = 0; n55 = 0;
        rst_n = 1'b0;
        init_start = 1'b0;

        //           cmd0_bad cmd8_resp          cmd55 busy final cmd58_resp          done code hc n55
        vecs[0] = '{0, 40'h01_0000_01AA, 8'h01, 2, 8'h00, 40'h00_C0FF_8000, 1'b1, 3'd0, 1'b1, 3};
        vecs[1] = '{0, 40'h05_FFFF_FFFF, 8'h01, 1, 8'h00, 40'h00_0000_0000, 1'b1, 3'd0, 1'b0, 2};
        vecs[2] = '{2, 40'h01_0000_01AA, 8'h00, 0, 8'h00, 40'h00_80FF_8000, 1'b1, 3'd0, 1'b0, 1};
        vecs[3] = '{0, 40'h01_0000_01AB, 8'h01, 0, 8'h00, 40'h00_0000_0000, 1'b0, 3'd2, 1'b0, 0};
        vecs[4] = '{0, 40'h01_0000_01AA, 8'h05, 0, 8'h00, 40'h00_0000_0000, 1'b0, 3'd3, 1'b0, 1};
        vecs[5] = '{0, 40'h01_0000_01AA, 8'h01, 1, 8'h04, 40'h00_0000_0000, 1'b0, 3'd4, 1'b0, 2};
        vecs[6] = '{0, 40'h01_0000_01AA, 8'h01, 0, 8'h00, 40'h01_C0FF_8000, 1'b0, 3'd5, 1'b0, 1};
        vecs[7] = '{0, 40'h04_FFFF_FFFF, 8'h01, 0, 8'h00, 40'h00_0000_0000, 1'b0, 3'd2, 1'b0, 0};
        cur = vecs[0];

        repeat (3) @(negedge clk);
        check("rst_outputs",
              64'({init_done, init_error, err_code, card_hc, spi_start, clk_ss, cs_force_high}), 64'd0);
        check("rst_frame", 64'(cmd_frame), 64'd0);
        check("rst_lengths", 64'({cmd_length, response_length}), 64'd0);
        check("rst_data_lengths", 64'({receive_data_length, send_data_length}), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(i);

        // No card: every transaction completes without a response.
        cur = '{100, 40'h0, 8'h0, 0, 8'h0, 40'h0, 1'b0, 3'd1, 1'b0, 0};
        n0 = 0; n41 = 0; n55 = 0;
        exp_q.delete();
        exp_q.push_back(mk(F_PWR, 6'd10, 6'd0, 1'b1));
        for (int j = 0; j < 8; j++) exp_q.push_back(mk(F_CMD0, 6'd6, 6'd1, 1'b0));
        resp_mode = 0;
        pulse_start("nocard");
        wait_end("nocard");
        repeat (30) @(negedge clk);
        check("nocard_error", 64'(init_error), 64'd1);
        check("nocard_err_code", 64'(err_code), 64'd1);
        check("nocard_clk_ss", 64'(clk_ss), 64'd0);
        check("nocard_n_cmd0", 64'(n0), 64'd8);
        check("nocard_sb_drained", 64'(exp_q.size()), 64'd0);

        // SPI master never reports busy.
        resp_mode = 1;
        pulse_start("tmo");
        c = 0;
        while (!spi_start && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("tmo_start_seen", 64'(spi_start), 64'd1);
        check("tmo_pwrup_cfg", 64'({cs_force_high, cmd_length, response_length}),
              64'({1'b1, 6'd10, 6'd0}));
        check("tmo_pwrup_frame", 64'(cmd_frame), 64'(F_PWR));
        n = 0;
        held = 1'b1;
        while (n < TB_TIMEOUT + 50) begin
            @(negedge clk);
            n++;
            if (init_error) break;
            held &= spi_start;
        end
        check("tmo_start_held", 64'(held), 64'd1);
        check("tmo_cycles", 64'(n), 64'(TB_TIMEOUT));
        check("tmo_err_code", 64'(err_code), 64'd6);
        check("tmo_spi_dropped", 64'(spi_start), 64'd0);
        check("tmo_clk_ss", 64'(clk_ss), 64'd0);

        // Asynchronous reset in the middle of the ACMD41 poll.
        cur = vecs[0];
        cur.a41_busy = 50;
        n0 = 0; n41 = 0; n55 = 0;
        exp_q.delete();
        push_expected(cur);
        resp_mode = 0;
        pulse_start("rst_mid");
        c = 0;
        while (n41 < 2 && c < 5000) begin
            @(negedge clk);
            c++;
        end
        check("rst_mid_reached_acmd41", 64'(n41 >= 2), 64'd1);
        check("rst_mid_pre_spi_start", 64'(spi_start), 64'd1);
        check("rst_mid_pre_frame", 64'(cmd_frame), 64'(F_A41_V2));
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_spi_start", 64'(spi_start), 64'd0);
        check("rst_mid_status",
              64'({init_done, init_error, err_code, card_hc, clk_ss, cs_force_high}), 64'd0);
        check("rst_mid_frame", 64'(cmd_frame), 64'd0);
        check("rst_mid_lengths", 64'({cmd_length, response_length}), 64'd0);
        repeat (20) @(negedge clk);
        exp_q.delete();
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_mid_idle", 64'({spi_start, init_done, init_error}), 64'd0);
        run_vec(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
